// File: rtl/fib_disp_pkg.sv
// Shared types and constants for the Fibonacci BCD display slice.
package fib_disp_pkg;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam int unsigned W_DEF        = 64;
  localparam int unsigned DIGITS_DEF   = 20;
  localparam int unsigned DISP_DEF     = 4;
  localparam int unsigned SCAN_DIV_DEF = 50000;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Decimal digits of 2^w-1: floor(w*log10 2)+1, log10 2 ~ 0.30103
  function automatic int unsigned min_digits(input int unsigned w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/fib_seg7_dec.sv
// BCD digit to active-low 7-segment decoder; non-decimal codes and blank show dark.
module fib_seg7_dec
  import fib_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fib_bcd_display.sv
// Binary-to-BCD converter (shift-add-3) feeding a paged, multiplexed 7-seg display.
// Optional leading-zero blanking is enabled by defining BCD_BLANK_EN.
module fib_bcd_display
  import fib_disp_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned DIGITS   = DIGITS_DEF,
  parameter int unsigned DISP     = DISP_DEF,
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_data,
  output logic                  in_ready,
  input  logic                  page_next,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [2:0]            page,
  output logic [DISP-1:0]       an,
  output logic [6:0]            seg
);

  localparam int unsigned PAGES = DIGITS / DISP;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned IDX_W = (DISP > 1) ? $clog2(DISP) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < min_digits(W)) begin : g_chk_digits
    $error("DIGITS too small to hold a W-bit value");
  end
  if ((DIGITS % DISP) != 0 || PAGES > 8) begin : g_chk_pages
    $error("DIGITS must be a multiple of DISP with at most 8 pages");
  end

  state_t              state_q, state_d;
  logic [W-1:0]        shift_q, shift_d;
  logic [4*DIGITS-1:0] work_q, work_d, adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                bcd_valid_q, bcd_valid_d;
  logic [2:0]          page_q, page_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                started_q, started_d;
  logic [DISP-1:0]     an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                tick, blank;
  logic [DIG_W-1:0]    sel;
  logic [3:0]          digit;
  logic [6:0]          seg_dec;
`ifdef BCD_BLANK_EN
  logic [DIG_W-1:0]    msd_q, msd_d;
`endif

  always_comb begin
    adj = work_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end

    state_d     = state_q;
    shift_d     = shift_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
`ifdef BCD_BLANK_EN
    msd_d       = msd_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          work_d  = '0;
          cnt_d   = CNT_W'(W - 1);
          state_d = CONV;
        end
      end
      CONV: begin
        {work_d, shift_d} = {adj, shift_q} << 1;
        if (cnt_q == '0) state_d = LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      LOAD: begin
        bcd_d       = work_q;
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
`ifdef BCD_BLANK_EN
        msd_d = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (work_q[4*i +: 4] != 4'd0) msd_d = DIG_W'(i);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Page stepping and the digit-scan divider run independently of the converter.
  always_comb begin
    page_d = page_q;
    if (page_next) page_d = (page_q == 3'(PAGES - 1)) ? 3'd0 : page_q + 3'd1;

    tick      = (div_q == DIV_W'(SCAN_DIV - 1));
    div_d     = tick ? '0 : div_q + 1'b1;
    idx_d     = idx_q;
    started_d = started_q;
    if (tick) begin
      idx_d     = (idx_q == IDX_W'(DISP - 1)) ? '0 : idx_q + 1'b1;
      started_d = 1'b1;
    end

    sel   = DIG_W'(page_q) * DIG_W'(DISP) + DIG_W'(idx_q);
    digit = bcd_q[{sel, 2'b00} +: 4];
`ifdef BCD_BLANK_EN
    blank = (sel > msd_q);
`else
    blank = 1'b0;
`endif
    an_d  = started_q ? ~(DISP'(1) << idx_q) : '1;
    seg_d = started_q ? seg_dec : SEG_BLANK;
  end

  fib_seg7_dec u_dec (
    .bcd   (digit),
    .blank (blank),
    .seg   (seg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      page_q      <= '0;
      div_q       <= '0;
      idx_q       <= '0;
      started_q   <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
`ifdef BCD_BLANK_EN
      msd_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      page_q      <= page_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      started_q   <= started_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
`ifdef BCD_BLANK_EN
      msd_q       <= msd_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign bcd_valid = bcd_valid_q;
  assign bcd_out   = bcd_q;
  assign page      = page_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_fib_bcd_display.sv
// Randomized self-checking bench for fib_bcd_display against a decimal-arithmetic model.
module tb_fib_bcd_display;

  localparam int unsigned SCAN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        page_next;
  logic        bcd_valid;
  logic [79:0] bcd_out;
  logic [2:0]  page;
  logic [3:0]  an;
  logic [6:0]  seg;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic [63:0] cur_val;
  int unsigned exp_page;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  fib_bcd_display #(.W(64), .DIGITS(20), .DISP(4), .SCAN_DIV(SCAN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .page_next (page_next),
    .bcd_valid (bcd_valid),
    .bcd_out   (bcd_out),
    .page      (page),
    .an        (an),
    .seg       (seg)
  );

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] to_bcd(input logic [63:0] v);
    logic [79:0] r;
    logic [63:0] x;
    r = '0;
    x = v;
    for (int i = 0; i < 20; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int unsigned dec_digit(input logic [63:0] v, input int unsigned pos);
    logic [63:0] x;
    x = v;
    for (int unsigned i = 0; i < pos; i++) x = x / 10;
    return int'(x % 10);
  endfunction

  function automatic int unsigned num_digits(input logic [63:0] v);
    int unsigned n;
    logic [63:0] x;
    n = 1;
    x = v / 10;
    while (x != 0) begin
      n++;
      x = x / 10;
    end
    return n;
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned pos);
`ifdef BCD_BLANK_EN
    if (pos >= num_digits(cur_val)) return 7'h7F;
`endif
    return seg_tab[dec_digit(cur_val, pos)];
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ready_wait", 80'(in_ready), 80'(1));
  endtask

  task automatic do_convert(input logic [63:0] v, input bit pulse_at_load);
    int  n;
    bit  busy_ok;
    wait_ready();
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy_ok  = 1'b1;
    n = 0;
    while (n < 200) begin
      // junk offered while busy must be ignored
      if (n >= 2 && n < 60) begin
        in_valid = $urandom_range(0, 1);
        in_data  = {$urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
      if (pulse_at_load && n == 64) page_next = 1'b1;
      @(posedge clk); #1;
      n++;
      page_next = 1'b0;
      if (bcd_valid) break;
      if (in_ready) busy_ok = 1'b0;
    end
    in_valid = 1'b0;
    check_eq("latency", 80'(n), 80'(65));
    check_eq("busy_not_ready", 80'(busy_ok), 80'(1));
    check_eq("bcd_out", bcd_out, to_bcd(v));
    cur_val = v;
    if (pulse_at_load) exp_page = (exp_page + 1) % 5;
    check_eq("page_after_conv", 80'(page), 80'(exp_page));
    @(posedge clk); #1;
    check_eq("valid_one_cycle", 80'(bcd_valid), 80'(0));
  endtask

  task automatic pulse_page();
    page_next = 1'b1;
    @(posedge clk); #1;
    page_next = 1'b0;
    exp_page = (exp_page + 1) % 5;
    check_eq("page_step", 80'(page), 80'(exp_page));
  endtask

  task automatic check_display();
    logic [3:0]  seen;
    bit          hot_ok;
    int unsigned idx;
    seen   = '0;
    hot_ok = 1'b1;
    repeat (3) @(posedge clk);
    for (int c = 0; c < 8 * SCAN; c++) begin
      @(posedge clk); #1;
      if (an != 4'hF) begin
        if ($countones(~an) != 1) hot_ok = 1'b0;
        else begin
          idx = 0;
          for (int unsigned k = 0; k < 4; k++) if (!an[k]) idx = k;
          seen[idx] = 1'b1;
          check_eq("seg", 80'(seg), 80'(exp_seg(exp_page * 4 + idx)));
        end
      end
    end
    check_eq("an_onehot", 80'(hot_ok), 80'(1));
    check_eq("an_all_scanned", 80'(seen), 80'(4'hF));
  endtask

  task automatic back_to_back(input logic [63:0] a, input logic [63:0] b);
    int n, acc, v1, v2;
    bit prev_ready, busy_ok;
    wait_ready();
    in_valid = 1'b1;
    in_data  = a;
    @(posedge clk); #1;
    in_data = b;
    n = 0; acc = -1; v1 = -1; v2 = -1; busy_ok = 1'b1;
    while (n < 300 && v2 < 0) begin
      prev_ready = in_ready;
      @(posedge clk); #1;
      n++;
      if (prev_ready && acc < 0) begin
        acc = n;
        in_valid = 1'b0;
      end
      if (n < 65 && in_ready) busy_ok = 1'b0;
      if (bcd_valid) begin
        if (v1 < 0) begin
          v1 = n;
          check_eq("b2b_first", bcd_out, to_bcd(a));
        end else begin
          v2 = n;
          check_eq("b2b_second", bcd_out, to_bcd(b));
        end
      end
    end
    in_valid = 1'b0;
    check_eq("b2b_busy", 80'(busy_ok), 80'(1));
    check_eq("b2b_accept_gap", 80'(acc), 80'(66));
    check_eq("b2b_valid1", 80'(v1), 80'(65));
    check_eq("b2b_valid2", 80'(v2), 80'(131));
    cur_val = b;
  endtask

  task automatic reset_mid_conv(input logic [63:0] v);
    bit saw_valid;
    wait_ready();
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_eq("rst_ready", 80'(in_ready), 80'(1));
    check_eq("rst_bcd_out", bcd_out, 80'(0));
    check_eq("rst_page", 80'(page), 80'(0));
    check_eq("rst_valid", 80'(bcd_valid), 80'(0));
    exp_page = 0;
    cur_val  = 64'd0;
    @(negedge clk) reset = 1'b0;
    saw_valid = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bcd_valid) saw_valid = 1'b1;
    end
    check_eq("rst_no_valid", 80'(saw_valid), 80'(0));
    check_eq("rst_hold_out", bcd_out, 80'(0));
  endtask

  initial begin
    logic [63:0] v;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    page_next = 1'b0;
    exp_page  = 0;
    cur_val   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_ready", 80'(in_ready), 80'(1));
    check_eq("reset_valid", 80'(bcd_valid), 80'(0));
    check_eq("reset_bcd", bcd_out, 80'(0));
    check_eq("reset_page", 80'(page), 80'(0));
    check_eq("reset_an", 80'(an), 80'(4'hF));
    check_eq("reset_seg", 80'(seg), 80'(7'h7F));
    @(negedge clk) reset = 1'b0;

    do_convert(64'd0, 1'b0);
    check_display();
    do_convert(64'd55, 1'b0);
    check_display();
    do_convert(64'd12586269025, 1'b0);
    check_display();
    do_convert(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check_eq("max_bcd", bcd_out, 80'h18446744073709551615);
    check_display();
    repeat (5) begin
      pulse_page();
      check_display();
    end

    back_to_back(64'd832040, 64'd7540113804746346429);
    do_convert(64'd1234567890123, 1'b1);
    check_display();

    for (int t = 0; t < 10; t++) begin
      v = {$urandom, $urandom} >> $urandom_range(0, 63);
      do_convert(v, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) pulse_page();
      check_display();
    end

    reset_mid_conv(64'd98765432109876);
    v = {$urandom, $urandom};
    do_convert(v, 1'b0);
    check_display();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
